adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 The block SHALL have no parameters: four requesters and 16-bit operands are fixed.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  4  per-requester level request; bit i = requester i.
REQ-005 a_in  input  64  packed A operands; requester i at bits [16i+15:16i].
REQ-006 b_in  input  64  packed B operands, same packing as a_in.
REQ-007 gnt  output  4  one-hot grant pulse; operands of that requester captured.
REQ-008 rsp_valid  output  1  result valid.
REQ-009 rsp_ready  input  1  consumer accepts the result.
REQ-010 rsp_id  output  2  index of the requester that owns the result.
REQ-011 rsp_sum  output  16  sum.
REQ-012 rsp_cout  output  1  carry out of bit 15.
REQ-013 busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 The block SHALL share one instance of the team 16-bit carry-select adder (modifiedcarry_adder) among the four requesters.
REQ-015 The FSM SHALL have three states: IDLE, CALC and RESP.
REQ-016 IDLE with req==0 SHALL remain in IDLE.
REQ-017 IDLE with req!=0 SHALL do all of the following on the next edge: pick a winner by round-robin; register the winner's a/b slices into operand registers; set gnt to the one-hot winner for exactly one cycle; latch rsp_id; go to CALC.
REQ-018 Round-robin SHALL search from the priority pointer upward, modulo 4.
REQ-019 The pointer SHALL be set to (winner+1) mod 4 at the grant edge.
REQ-020 CALC SHALL last exactly one cycle: register the adder outputs into rsp_sum/rsp_cout, set rsp_valid=1 and go to RESP.
REQ-021 RESP SHALL hold rsp_valid, rsp_sum, rsp_cout and rsp_id stable until rsp_ready=1.
REQ-022 On the handshake edge in RESP, rsp_valid SHALL go to 0 and the FSM SHALL go to IDLE.
REQ-023 Latency SHALL be: req sampled at edge 0, gnt high in cycle 1, rsp_valid high from cycle 2; minimum issue interval 3 cycles.
REQ-024 req and operand changes outside IDLE SHALL be ignored; a requester still asserting req after its gnt SHALL be treated as a new request.
REQ-025 A request withdrawn before its grant SHALL leave no state.
REQ-026 rsp_ready asserted while rsp_valid=0 SHALL have no effect.
REQ-027 Arithmetic SHALL be unsigned 16+16 giving a 17-bit {rsp_cout,rsp_sum} with no carry-in.
REQ-028 The outputs SHALL be bit-exact with the plain unsigned sum a+b.
REQ-029 All outputs SHALL be driven from flops.

Reset
REQ-030 While rst_n=0: state=IDLE, pointer=0, gnt=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, busy=0, operand registers=0.
REQ-031 Reset asserted mid-operation SHALL discard the operation without emitting a response.
REQ-032 The first IDLE cycle after deassertion SHALL arbitrate normally, starting from requester 0.

Configuration
REQ-033 Macro ADDER_ARB_SAT_EN defined: when the raw carry is 1, rsp_sum SHALL be 16'hFFFF and rsp_cout SHALL still report the raw carry.
REQ-034 Macro ADDER_ARB_SAT_EN undefined: rsp_sum SHALL be the wrapped sum; no saturation logic SHALL be synthesized.

Verification
REQ-035 Reset, then req=4'b0001 with a0=16'h1234, b0=16'h0F0F, rsp_ready=1 -> gnt=0001 in cycle 1; cycle 2 gives rsp_valid=1, rsp_id=0, rsp_sum=16'h2143, rsp_cout=0.
REQ-036 All four req held high continuously with rsp_ready=1 -> grant order 0,1,2,3,0; a grant every 3 cycles.
REQ-037 a=16'hFFFF, b=16'h0001 -> rsp_cout=1; rsp_sum=16'h0000 without ADDER_ARB_SAT_EN, 16'hFFFF with it.
REQ-038 rsp_ready=0 for 5 cycles while in RESP, with operands toggled -> outputs stable; busy=1; no gnt; response completes on the first rsp_ready=1 edge.
REQ-039 rst_n pulsed low during CALC -> rsp_valid never rises; after release, req=4'b1000 is granted first with gnt=1000.
REQ-040 Random operands on all requesters for 10k operations -> every {rsp_cout,rsp_sum} equals the 17-bit reference sum tagged with the correct rsp_id.

Source files
------------

// File: rtl/adder_arbiter_if.sv
// Request/response bundle between four adder requesters and the shared-adder arbiter.
interface adder_arbiter_if;
  logic [3:0]  req;
  logic [63:0] a_in;
  logic [63:0] b_in;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_sum;
  logic        rsp_cout;

  modport master (
    output req, a_in, b_in, rsp_ready,
    input  gnt, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    input  req, a_in, b_in, rsp_ready,
    output gnt, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one 16-bit carry-select adder among four requesters.
// Define ADDER_ARB_SAT_EN to saturate rsp_sum to 16'hFFFF on carry out.

module modifiedcarry_adder (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] sum_o,
  output logic        cout_o
);
  logic [4:0] c;
  logic [4:0] s0;
  logic [4:0] s1;

  // Each 4-bit block precomputes both carry-in cases; the incoming carry selects.
  always_comb begin
    c     = '0;
    sum_o = '0;
    s0    = '0;
    s1    = '0;
    for (int k = 0; k < 4; k++) begin
      s0 = {1'b0, a_i[4*k +: 4]} + {1'b0, b_i[4*k +: 4]};
      s1 = s0 + 5'd1;
      {c[k+1], sum_o[4*k +: 4]} = c[k] ? s1 : s0;
    end
    cout_o = c[4];
  end
endmodule

// state | meaning
// IDLE  | arbitrate pending requests, capture winner operands
// CALC  | shared adder evaluates captured operands
// RESP  | result presented until rsp_ready
module adder_arbiter (
  input  logic           clk,
  input  logic           rst_n,
  adder_arbiter_if.slave bus,
  output logic           busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, RESP = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [1:0]  id_q, id_d;
  logic [15:0] op_a_q, op_a_d;
  logic [15:0] op_b_q, op_b_d;
  logic [15:0] sum_q, sum_d;
  logic        cout_q, cout_d;
  logic        valid_q, valid_d;
  logic        busy_q;

  logic        found;
  logic [1:0]  win;
  logic [1:0]  idx;
  logic [15:0] add_sum;
  logic        add_cout;
  logic [15:0] res_sum;

  modifiedcarry_adder u_add (
    .a_i    (op_a_q),
    .b_i    (op_b_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

`ifdef ADDER_ARB_SAT_EN
  assign res_sum = add_cout ? 16'hFFFF : add_sum;
`else
  assign res_sum = add_sum;
`endif

  // First requester at or above the pointer, wrapping modulo 4.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    id_d    = id_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = 4'b0001 << win;
          id_d    = win;
          ptr_d   = win + 2'd1;
          op_a_d  = bus.a_in[{win, 4'b0000} +: 16];
          op_b_d  = bus.b_in[{win, 4'b0000} +: 16];
          state_d = CALC;
        end
      end
      CALC: begin
        sum_d   = res_sum;
        cout_d  = add_cout;
        valid_d = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      id_q    <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = cout_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized self-checking bench for adder_arbiter against a round-robin/sum reference model.
module tb_adder_arbiter;
  logic clk;
  logic rst_n;
  logic busy;
  int   n_chk;
  int   n_pass;
  int   m_ptr;

  adder_arbiter_if bus ();

  adder_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    chk("rst_gnt",   32'(bus.gnt), 0);
    chk("rst_valid", 32'(bus.rsp_valid), 0);
    chk("rst_id",    32'(bus.rsp_id), 0);
    chk("rst_sum",   {15'd0, bus.rsp_cout, bus.rsp_sum}, 0);
    chk("rst_busy",  32'(busy), 0);
    rst_n = 1'b1;
    m_ptr = 0;
  endtask

  function automatic logic [16:0] ref_sum(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] e;
    e = {1'b0, a} + {1'b0, b};
`ifdef ADDER_ARB_SAT_EN
    if (e[16]) e[15:0] = 16'hFFFF;
`endif
    return e;
  endfunction

  // One full transaction from IDLE; operands/req scrambled after grant to show they are ignored.
  task automatic run_op(input logic [3:0] r, input logic [63:0] a, input logic [63:0] b,
                        input int stall);
    int w;
    logic [16:0] e;
    bus.req       = r;
    bus.a_in      = a;
    bus.b_in      = b;
    bus.rsp_ready = 1'b0;
    if (r == 4'b0000) begin
      bus.rsp_ready = 1'b1;
      tick();
      chk("idle_gnt",   32'(bus.gnt), 0);
      chk("idle_valid", 32'(bus.rsp_valid), 0);
      chk("idle_busy",  32'(busy), 0);
      return;
    end
    w = -1;
    for (int k = 0; k < 4; k++)
      if (w < 0 && r[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
    m_ptr = (w + 1) % 4;
    e = ref_sum(a[16*w +: 16], b[16*w +: 16]);

    tick();
    chk("gnt",       32'(bus.gnt), 32'(1) << w);
    chk("gnt_valid", 32'(bus.rsp_valid), 0);
    chk("gnt_busy",  32'(busy), 1);
    bus.req  = 4'($urandom);
    bus.a_in = {$urandom, $urandom};
    bus.b_in = {$urandom, $urandom};

    tick();
    chk("gnt_pulse", 32'(bus.gnt), 0);
    chk("rsp_valid", 32'(bus.rsp_valid), 1);
    chk("rsp_id",    32'(bus.rsp_id), 32'(w));
    chk("rsp_sum",   {15'd0, bus.rsp_cout, bus.rsp_sum}, {15'd0, e});
    for (int s = 0; s < stall; s++) begin
      bus.req  = 4'($urandom);
      bus.a_in = {$urandom, $urandom};
      bus.b_in = {$urandom, $urandom};
      tick();
      chk("hold_valid", 32'(bus.rsp_valid), 1);
      chk("hold_id",    32'(bus.rsp_id), 32'(w));
      chk("hold_sum",   {15'd0, bus.rsp_cout, bus.rsp_sum}, {15'd0, e});
      chk("hold_gnt",   32'(bus.gnt), 0);
      chk("hold_busy",  32'(busy), 1);
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("done_valid", 32'(bus.rsp_valid), 0);
    chk("done_busy",  32'(busy), 0);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    do_reset();

    // Directed first transaction.
    run_op(4'b0001, 64'h0000_0000_0000_1234, 64'h0000_0000_0000_0F0F, 0);

    // Overflow case on requester 2.
    run_op(4'b0100, 64'h0000_FFFF_0000_0000, 64'h0000_0001_0000_0000, 0);

    // Long stall in RESP with toggling inputs.
    run_op(4'b1010, {$urandom, $urandom}, {$urandom, $urandom}, 5);

    // Withdrawn / absent requests leave no state.
    run_op(4'b0000, '0, '0, 0);

    // All requesters held: rotation 0,1,2,3,0 with a grant every 3 cycles.
    do_reset();
    bus.req       = 4'b1111;
    bus.rsp_ready = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      tick();
      chk("rr_gnt", 32'(bus.gnt), (c % 3 == 1) ? (32'(1) << ((c / 3) % 4)) : 0);
    end
    bus.req = 4'b0000;

    // Reset during CALC discards the operation; pointer restarts at 0.
    do_reset();
    bus.req  = 4'b0100;
    bus.a_in = {$urandom, $urandom};
    bus.b_in = {$urandom, $urandom};
    tick();
    chk("pre_rst_gnt", 32'(bus.gnt), 32'h4);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_valid", 32'(bus.rsp_valid), 0);
    chk("mid_rst_busy",  32'(busy), 0);
    rst_n = 1'b1;
    m_ptr = 0;
    bus.req = 4'b0000;
    run_op(4'b1000, {$urandom, $urandom}, {$urandom, $urandom}, 0);

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 16 == 0) begin
        ra[15:0] = 16'hFFFF;
        rb[15:0] = 16'(16'h0001 + 16'($urandom_range(0, 3)));
      end
      run_op(4'($urandom_range(0, 15)), ra, rb, ($urandom_range(0, 7) == 0) ? 2 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
